// File: rtl/nibble_capture_fifo.sv
// Edge-triggered nibble capture FIFO: STB rising edge pushes DIN, RD rising edge pops.
// Define NIBBLE_CAPTURE_SYNC_EN to add two-flop synchronizers on STB/RD (+2 cycles latency).
module nibble_capture_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             STB,
    input  logic             RD,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF,
    output logic [CW-1:0]    COUNT
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef NIBBLE_CAPTURE_SYNC_EN
    // Pulses are suppressed until a high pin has reached the edge flop after reset.
    localparam logic [1:0] ARM_CYC = 2'd3;

    logic [1:0] stb_sync;
    logic [1:0] rd_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stb_sync <= '0;
            rd_sync  <= '0;
        end else begin
            stb_sync <= {stb_sync[0], STB};
            rd_sync  <= {rd_sync[0], RD};
        end
    end

    wire stb_i = stb_sync[1];
    wire rd_i  = rd_sync[1];
`else
    localparam logic [1:0] ARM_CYC = 2'd1;

    wire stb_i = STB;
    wire rd_i  = RD;
`endif

    logic             stb_q;
    logic             rd_q;
    logic [1:0]       arm_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic [WIDTH-1:0] mem [DEPTH];

    logic armed;
    logic push_p;
    logic pop_p;
    logic push_ok;
    logic pop_ok;

    // Edge detection, gated by the post-reset arming window.
    always_comb begin
        armed   = (arm_cnt == ARM_CYC);
        push_p  = stb_i & ~stb_q & armed;
        pop_p   = rd_i & ~rd_q & armed;
        pop_ok  = pop_p & (count != '0);
        push_ok = push_p & ((count < CW'(DEPTH)) | pop_ok);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stb_q   <= 1'b0;
            rd_q    <= 1'b0;
            arm_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            stb_q <= stb_i;
            rd_q  <= rd_i;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            if (push_p && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage array is deliberately left uncleared by reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= DIN;
        end
    end

    assign EMPTY = (count == '0);
    assign FULL  = (count == CW'(DEPTH));
    assign OVF   = ovf;
    assign COUNT = count;
    assign DOUT  = EMPTY ? '0 : mem[rd_ptr];

endmodule
